// File: rtl/inst_fetch_buffer_if.sv
// Fetch-buffer bus bundle: instruction ROM port, branch redirect and decode handshake.
// The master modport is the fetch buffer side; the slave modport is the ROM/PC/decode side.
interface inst_fetch_buffer_if;
    logic [31:0] rom_addr_o;
    logic        rom_ce_o;
    logic [31:0] rom_data_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;

    modport master (
        output rom_addr_o, rom_ce_o, id_valid_o, id_pc_o, id_inst_o,
        input  rom_data_i, branch_flag_i, branch_target_i, id_ready_i
    );

    modport slave (
        input  rom_addr_o, rom_ce_o, id_valid_o, id_pc_o, id_inst_o,
        output rom_data_i, branch_flag_i, branch_target_i, id_ready_i
    );
endinterface

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch front end: drives the ROM, buffers {pc, inst} pairs in a small FIFO,
// and hands them to decode over valid/ready. A branch flushes the FIFO and redirects fetch.
module inst_fetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    inst_fetch_buffer_if.master        bus,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];

    logic          push, pop, started, not_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Fetch is held off for exactly one edge after reset release.
    always_comb begin
        state_d = state_q;
        started = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN:  started = 1'b1;
            default: state_d = ST_IDLE;
        endcase
    end

    assign not_empty = (count != '0);
    assign push      = started && (count != FULL) && !bus.branch_flag_i;
    assign pop       = not_empty && !bus.branch_flag_i && bus.id_ready_i;

    assign bus.rom_ce_o   = push;
    assign bus.rom_addr_o = fetch_pc;
    assign bus.id_valid_o = not_empty && !bus.branch_flag_i;
    assign bus.id_pc_o    = not_empty ? pc_mem[rd_ptr]   : '0;
    assign bus.id_inst_o  = not_empty ? inst_mem[rd_ptr] : '0;
    assign count_o        = count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (bus.branch_flag_i) begin
            fetch_pc <= {bus.branch_target_i[31:2], 2'b00};
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
                wr_ptr   <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= fetch_pc;
            inst_mem[wr_ptr] <= bus.rom_data_i;
        end
    end
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed bench for inst_fetch_buffer (DEPTH=4, RESET_PC=0) with a ROM returning 0x1000+word index.
module tb_inst_fetch_buffer;
    logic       clk;
    logic       rst;
    logic [2:0] count_o;
    int unsigned checks   = 0;
    int unsigned failures = 0;

    inst_fetch_buffer_if bus ();

    inst_fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .count_o (count_o)
    );

    assign bus.rom_data_i = 32'h1000 + (bus.rom_addr_o >> 2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready);
        @(negedge clk);
        rst = 1'b0;
        bus.id_ready_i = ready;
        bus.branch_flag_i = 1'b0;
        #1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("pre_start_ce", {31'd0, bus.rom_ce_o}, 32'd0);
    endtask

    task automatic startup_seq(input string tag);
        step();
        check({tag, "_e1_ce"},    {31'd0, bus.rom_ce_o},   32'd1);
        check({tag, "_e1_addr"},  bus.rom_addr_o,          32'h0);
        check({tag, "_e1_valid"}, {31'd0, bus.id_valid_o}, 32'd0);
        step();
        check({tag, "_e2_valid"}, {31'd0, bus.id_valid_o}, 32'd1);
        check({tag, "_e2_pc"},    bus.id_pc_o,             32'h0);
        check({tag, "_e2_inst"},  bus.id_inst_o,           32'h1000);
        check({tag, "_e2_addr"},  bus.rom_addr_o,          32'h4);
    endtask

    initial begin
        rst = 1'b0;
        bus.id_ready_i = 1'b1;
        bus.branch_flag_i = 1'b0;
        bus.branch_target_i = '0;
        #2;
        check("rst_ce",    {31'd0, bus.rom_ce_o},   32'd0);
        check("rst_addr",  bus.rom_addr_o,          32'h0);
        check("rst_valid", {31'd0, bus.id_valid_o}, 32'd0);
        check("rst_count", {29'd0, count_o},        32'd0);
        check("rst_pc",    bus.id_pc_o,             32'h0);
        check("rst_inst",  bus.id_inst_o,           32'h0);

        // Startup and full-rate streaming
        do_reset(1'b1);
        startup_seq("start");
        for (int i = 1; i <= 4; i++) begin
            step();
            check("stream_pc",    bus.id_pc_o,        32'(4 * i));
            check("stream_inst",  bus.id_inst_o,      32'h1000 + 32'(i));
            check("stream_count", {29'd0, count_o},   32'd1);
        end

        // Backpressure: fill to DEPTH, then drain in order
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) step();
        check("bp_count", {29'd0, count_o},      32'd4);
        check("bp_ce",    {31'd0, bus.rom_ce_o}, 32'd0);
        check("bp_addr",  bus.rom_addr_o,        32'h10);
        step();
        check("bp_hold_pc",    bus.id_pc_o,       32'h0);
        check("bp_hold_count", {29'd0, count_o},  32'd4);
        bus.id_ready_i = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("drain_pc",   bus.id_pc_o,   32'(4 * k));
            check("drain_inst", bus.id_inst_o, 32'h1000 + 32'(k));
        end
        check("drain_count", {29'd0, count_o}, 32'd3);

        // Branch with three entries buffered
        bus.branch_flag_i = 1'b1;
        bus.branch_target_i = 32'h40;
        #1;
        check("br_valid", {31'd0, bus.id_valid_o}, 32'd0);
        check("br_ce",    {31'd0, bus.rom_ce_o},   32'd0);
        step();
        bus.branch_flag_i = 1'b0;
        #1;
        check("br_count", {29'd0, count_o},        32'd0);
        check("br_addr",  bus.rom_addr_o,          32'h40);
        check("br_ce2",   {31'd0, bus.rom_ce_o},   32'd1);
        step();
        check("br_pc",    bus.id_pc_o,             32'h40);
        check("br_inst",  bus.id_inst_o,           32'h1010);
        check("br_valid2",{31'd0, bus.id_valid_o}, 32'd1);

        // Misaligned target is word-aligned
        bus.branch_flag_i = 1'b1;
        bus.branch_target_i = 32'h43;
        step();
        bus.branch_flag_i = 1'b0;
        #1;
        check("mis_addr", bus.rom_addr_o, 32'h40);

        // Back-to-back branches: last wins
        bus.branch_flag_i = 1'b1;
        bus.branch_target_i = 32'h80;
        step();
        bus.branch_target_i = 32'h100;
        step();
        bus.branch_flag_i = 1'b0;
        #1;
        check("b2b_addr", bus.rom_addr_o, 32'h100);
        step();
        check("b2b_pc",   bus.id_pc_o,    32'h100);
        check("b2b_inst", bus.id_inst_o,  32'h1040);

        // Fetch address wraps past the top of the address space
        bus.branch_flag_i = 1'b1;
        bus.branch_target_i = 32'hFFFF_FFFC;
        step();
        bus.branch_flag_i = 1'b0;
        step();
        check("wrap_pc0",   bus.id_pc_o,   32'hFFFF_FFFC);
        check("wrap_inst0", bus.id_inst_o, 32'h4000_0FFF);
        step();
        check("wrap_pc1",   bus.id_pc_o,   32'h0);
        check("wrap_inst1", bus.id_inst_o, 32'h1000);

        // Asynchronous reset between edges with three entries buffered
        bus.id_ready_i = 1'b0;
        step();
        step();
        check("ar_pre_count", {29'd0, count_o}, 32'd3);
        #2;
        rst = 1'b0;
        #1;
        check("ar_valid", {31'd0, bus.id_valid_o}, 32'd0);
        check("ar_count", {29'd0, count_o},        32'd0);
        check("ar_ce",    {31'd0, bus.rom_ce_o},   32'd0);
        check("ar_addr",  bus.rom_addr_o,          32'h0);
        check("ar_pc",    bus.id_pc_o,             32'h0);
        do_reset(1'b1);
        startup_seq("restart");
        step();
        check("restart_pc3", bus.id_pc_o, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/inst_fetch_buffer.md
# inst_fetch_buffer

Instruction fetch front end between the PC logic and the decode stage. It drives the instruction ROM's address/enable interface, captures each returned instruction together with its PC into a small prefetch FIFO, and presents entries to decode through a valid/ready handshake. A branch redirect flushes all buffered entries and restarts fetch at the target.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; word-aligned.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low (0 = in reset).
- `rom_addr_o`  out  32  ROM fetch address; equals `fetch_pc`.
- `rom_ce_o`  out  1  ROM chip enable; a push happens on every edge where it is 1.
- `rom_data_i`  in  32  ROM read data; combinational and valid in the same cycle as `rom_addr_o` when `rom_ce_o`=1.
- `branch_flag_i`  in  1  redirect request, one cycle.
- `branch_target_i`  in  32  redirect address.
- `id_valid_o`  out  1  head entry is valid.
- `id_ready_i`  in  1  decode accepts the head entry.
- `id_pc_o`  out  32  PC of the head entry.
- `id_inst_o`  out  32  instruction word of the head entry.
- `count_o`  out  log2(DEPTH)+1  number of occupied entries.

## Operation
- State:
  - `fetch_pc` (32 bits).
  - `started` flag.
  - FIFO storage of {pc, inst} pairs.
  - Read/write pointers of log2(DEPTH) bits, wrapping modulo DEPTH.
  - `count`.
- Reset (rst=0, takes effect immediately with no clock):
  - `fetch_pc` = RESET_PC, `started` = 0, pointers = 0, `count` = 0.
  - Outputs: `rom_ce_o`=0, `rom_addr_o`=RESET_PC, `id_valid_o`=0, `id_pc_o`=0, `id_inst_o`=0, `count_o`=0.
- Startup: `started` becomes 1 on the first rising edge after `rst` deasserts. No fetch happens before that.
- `rom_ce_o` = `started` & (`count` < DEPTH) & !`branch_flag_i`.
- Push (edge with `rom_ce_o`=1):
  - Write {`fetch_pc`, `rom_data_i`} at the write pointer and advance the pointer.
  - `fetch_pc` <= `fetch_pc` + 4. Arithmetic is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Pop:
  - `id_valid_o` = (`count` != 0) & !`branch_flag_i`.
  - A pop happens on an edge where `id_valid_o` & `id_ready_i`; it advances the read pointer.
- Head outputs:
  - `id_pc_o` and `id_inst_o` show the entry at the read pointer.
  - When `count`=0 they are 0.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Full (`count`=DEPTH): no push, even if a pop occurs in the same cycle. A pop from full re-enables fetch on the next cycle.
- Branch (`branch_flag_i`=1 at an edge) has priority over push and pop:
  - Pointers = 0, `count` = 0.
  - `fetch_pc` <= {`branch_target_i`[31:2], 2'b00}; the low bits are forced to 0.
  - No push or pop occurs in the branch cycle. All buffered entries are discarded.
  - Branches on consecutive cycles: the last one wins.
- Branch before `started`=1: `fetch_pc` is still loaded with the target.

## Timing
- Fetch-to-decode latency:
  - An instruction is pushed on the edge that ends its ROM cycle.
  - It is visible at `id_*` in the following cycle if the FIFO was empty.
- Startup sequence:
  - Edge 1 after release: `started`=1, and `rom_ce_o`=1 with address RESET_PC.
  - Edge 2: first push. `id_valid_o`=1 from then on.
- Throughput: 1 instruction per cycle while `id_ready_i`=1 continuously.
- Redirect latency:
  - The cycle after a branch edge has `rom_addr_o`=target and `rom_ce_o`=1 (if no new branch).
  - The target instruction appears at `id_*` one cycle after that.
- `count_o` and the `id_*` outputs are registered state or a mux of registered state. The only combinational path is `branch_flag_i` into `id_valid_o` and `rom_ce_o`.
- Reset asserted mid-operation: all state clears asynchronously and in-flight entries are lost. After release, the startup sequence repeats.

## Test plan
- Startup, RESET_PC=0, ROM word i = 32'h1000+i, `id_ready_i`=1:
  - `rom_addr_o` steps 0, 4, 8, ….
  - `id_valid_o` rises after the 2nd edge with `id_pc_o`=0, `id_inst_o`=32'h1000.
  - Then one entry per cycle (4 → 32'h1001, …).
- Backpressure, `id_ready_i`=0 from startup:
  - After 4 pushes, `count_o`=4, `rom_ce_o`=0, and `rom_addr_o` holds 32'h10; the head stays at pc 0.
  - Raise ready: entries pop in order 0, 4, 8, C, 10, … with no gaps or duplicates.
- Branch with `count_o`=3, one-cycle `branch_flag_i`, target 32'h40:
  - In the branch cycle `id_valid_o`=0 and `rom_ce_o`=0.
  - Next cycle: `count_o`=0 and `rom_addr_o`=32'h40.
  - Following cycle: `id_pc_o`=32'h40, `id_inst_o`=32'h1010.
- Misaligned target 32'h43: the fetch address is 32'h40. Back-to-back branches to 32'h80 then 32'h100: fetch resumes at 32'h100.
- Wrap: branch to 32'hFFFF_FFFC; consecutive popped PCs are 32'hFFFF_FFFC, then 32'h0.
- Async reset mid-stream with `count_o`=3, `rst` pulled low between edges:
  - Immediately: `id_valid_o`=0, `count_o`=0, `rom_ce_o`=0, `rom_addr_o`=RESET_PC.
  - After release: the startup sequence repeats exactly.
